cdf_accumulator: RTL

Producer side of the histogram-equalization divider interface. Scans the histogram memory bin by bin, forms the running cumulative distribution (CDF), and presents each CDF value on `cdf_out` with a one-cycle `div_en` strobe. It then waits for the divider's `ready_g_out` before advancing to the next bin. Sits between the histogram RAM and the divider; one `start` produces exactly BINS divider transactions.

---
 rtl/cdf_accumulator.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cdf_accumulator.sv
// Histogram CDF producer for the equalization divider: reads one bin at a time,
// keeps a saturating running sum and hands each value to the divider with a strobe/ready handshake.
module cdf_accumulator #(
    parameter int BINS   = 256,
    parameter int ADDR_W = 8,
    parameter int HIST_W = 32,
    parameter int CDF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              hist_rd_en,
    output logic [ADDR_W-1:0] hist_addr,
    input  logic [HIST_W-1:0] hist_data,
    output logic [CDF_W-1:0]  cdf_out,
    output logic              div_en,
    input  logic              div_ready,
    output logic [ADDR_W-1:0] bin_idx,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LAT   = 3'd2,
        ISSUE = 3'd3,
        WAITD = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BINS - 1);

    // Returns {carry, value}; on carry the value is pinned to all ones.
    function automatic logic [CDF_W:0] sat_add(input logic [CDF_W-1:0] a,
                                               input logic [HIST_W-1:0] b);
        logic [CDF_W:0] sum;
        sum = {1'b0, a} + {{(CDF_W + 1 - HIST_W){1'b0}}, b};
        if (sum[CDF_W]) begin
            sat_add = {1'b1, {CDF_W{1'b1}}};
        end else begin
            sat_add = sum;
        end
    endfunction

    state_t              state_r, state_s;
    logic [CDF_W-1:0]    acc_r, acc_s;
    logic [ADDR_W-1:0]   idx_r, idx_s;
    logic                ovf_r, ovf_s;
    logic [CDF_W:0]      sum_s;

    logic                hist_rd_en_r;
    logic [ADDR_W-1:0]   hist_addr_r;
    logic [CDF_W-1:0]    cdf_out_r;
    logic                div_en_r;
    logic [ADDR_W-1:0]   bin_idx_r;
    logic                busy_r;
    logic                done_r;

    assign sum_s = sat_add(acc_r, hist_data);

    // Next-state and datapath update for the scan sequence.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        idx_s   = idx_r;
        ovf_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_s   = {CDF_W{1'b0}};
                    idx_s   = {ADDR_W{1'b0}};
                    ovf_s   = 1'b0;
                    state_s = RD;
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                state_s = LAT;
            end
            LAT: begin
                acc_s = sum_s[CDF_W-1:0];
                if (sum_s[CDF_W]) begin
                    ovf_s = 1'b1;
                end else begin
                    ovf_s = ovf_r;
                end
                state_s = ISSUE;
            end
            ISSUE: begin
                state_s = WAITD;
            end
            WAITD: begin
                // Ready is only honoured here, so a pulse coinciding with ISSUE is dropped.
                if (div_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = FIN;
                    end else begin
                        idx_s   = idx_r + ADDR_W'(1'b1);
                        state_s = RD;
                    end
                end else begin
                    state_s = WAITD;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, accumulator and outputs; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            acc_r        <= {CDF_W{1'b0}};
            idx_r        <= {ADDR_W{1'b0}};
            ovf_r        <= 1'b0;
            hist_rd_en_r <= 1'b0;
            hist_addr_r  <= {ADDR_W{1'b0}};
            cdf_out_r    <= {CDF_W{1'b0}};
            div_en_r     <= 1'b0;
            bin_idx_r    <= {ADDR_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            acc_r        <= acc_s;
            idx_r        <= idx_s;
            ovf_r        <= ovf_s;
            hist_rd_en_r <= (state_s == RD);
            div_en_r     <= (state_s == ISSUE);
            busy_r       <= (state_s != IDLE);
            done_r       <= (state_s == FIN);
            if (state_s == RD) begin
                hist_addr_r <= idx_s;
            end
            if (state_s == ISSUE) begin
                cdf_out_r <= acc_s;
                bin_idx_r <= idx_s;
            end
        end
    end

    assign hist_rd_en = hist_rd_en_r;
    assign hist_addr  = hist_addr_r;
    assign cdf_out    = cdf_out_r;
    assign div_en     = div_en_r;
    assign bin_idx    = bin_idx_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign overflow   = ovf_r;

endmodule
